serial_io_poller: RTL
=====================

SERIAL_IO_POLLER -- requirements
Module: serial_io_poller

Interface
REQ-001 SHALL have parameter BUS_WAIT, default 4, meaning the number of clock cycles each bus access holds IOSelect_H high (legal range 2..15).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning the RX and TX FIFO depth in bytes (power of 2).
REQ-003 SHALL have parameter POLL_GAP, default 2, meaning the idle cycles after a poll finds nothing to do.
REQ-004 SHALL have port Clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port Reset_H, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port Enable, input, 1 bit: polling is permitted while high.
REQ-007 SHALL have port PortSel, input, 2 bits: UART select (0 = Bluetooth, 1 = WiFi, 2 = USB, 3 = none).
REQ-008 SHALL have port TxData, input, 8 bits: byte to transmit.
REQ-009 SHALL have ports TxValid (input, 1 bit) and TxReady (output, 1 bit): the TX push handshake.
REQ-010 SHALL have port RxData, output, 8 bits: received byte at the RX FIFO head.
REQ-011 SHALL have ports RxValid (output, 1 bit) and RxReady (input, 1 bit): the RX pop handshake.
REQ-012 SHALL have port Address, output, 16 bits: bus address A15:A0.
REQ-013 SHALL have ports IOSelect_H (output, 1 bit) and ByteSelect_L (output, 1 bit): the IO window strobe and the even-byte select.
REQ-014 SHALL have port WE_L, output, 1 bit: write enable, active low.
REQ-015 SHALL have port BusWrData, output, 8 bits: write data for D15-D8.
REQ-016 SHALL have port BusRdData, input, 8 bits: read data from D15-D8.
REQ-017 SHALL have ports Busy (output, 1 bit, high when the FSM is not IDLE) and RxOverrun (output, 1 bit, sticky).

Function
REQ-018 SHALL use base address 0x0200 for PortSel 0, 0x0210 for PortSel 1 and 0x0220 for PortSel 2; RBR/THR SHALL be at base+0x0 and LSR at base+0xA.
REQ-019 SHALL implement FSM states IDLE, RD_LSR, DECIDE, RD_RBR, WR_THR, GAP.
REQ-020 IDLE SHALL go to RD_LSR when Enable=1 and PortSel!=3, and SHALL latch PortSel at that transition; later PortSel changes SHALL be ignored until the next IDLE.
REQ-021 Each access state SHALL drive Address, IOSelect_H=1 and ByteSelect_L=0 for exactly BUS_WAIT cycles; WE_L SHALL be 0 only in WR_THR.
REQ-022 Read states SHALL sample BusRdData on the clock edge that ends the final access cycle.
REQ-023 Outside access states, IOSelect_H SHALL be 0, ByteSelect_L SHALL be 1 and WE_L SHALL be 1.
REQ-024 DECIDE SHALL last 1 cycle with the following priority:
- LSR[0]=1 and the RX FIFO not full -> RD_RBR;
- otherwise LSR[5]=1 and the TX FIFO not empty -> WR_THR;
- otherwise -> GAP for POLL_GAP cycles.
REQ-025 RD_RBR SHALL push the sampled byte into the RX FIFO; WR_THR SHALL pop the TX FIFO head at access end.
REQ-026 After RD_RBR or WR_THR, the FSM SHALL spend 1 GAP cycle; after GAP it SHALL return to IDLE, so consecutive accesses are separated by at least 1 cycle with IOSelect_H=0.
REQ-027 LSR[1]=1 sampled in RD_LSR SHALL set RxOverrun, which SHALL be cleared only by reset.
REQ-028 Enable falling mid-access SHALL let the current access complete, then go to GAP and then IDLE.
REQ-029 TxReady SHALL equal "TX FIFO not full"; RxValid SHALL equal "RX FIFO not empty".
REQ-030 A simultaneous push and pop on the same FIFO SHALL be legal at any occupancy, including full for a pop-then-push and empty for a push-then-pop with no bypass; RxData SHALL be registered.
REQ-031 FIFO pointers SHALL wrap modulo FIFO_DEPTH; a push when full or a pop when empty SHALL be ignored.

Reset
REQ-032 Reset_H SHALL force, on the next edge: FSM=IDLE, both FIFOs empty, IOSelect_H=0, ByteSelect_L=1, WE_L=1, Address=0, BusWrData=0, RxData=0, RxValid=0, TxReady=1, Busy=0, RxOverrun=0.
REQ-033 Reset asserted mid-access SHALL abort the access immediately; a partially written THR byte SHALL be dropped and not retried.

Structure
REQ-034 Port base addresses, register offsets (RBR/THR=0x0, LSR=0xA), LSR bit positions (DR=0, OE=1, THRE=5) and the FSM state encoding SHALL live in the shared package serial_io_pkg.
REQ-035 Both FIFOs SHALL be instances of a single sub-module, sync_byte_fifo.

Verification
REQ-036 PortSel=1, LSR returns 0x01 then RBR returns 0x5A -> Address 0x021A for 4 cycles, then 0x0210 for 4 cycles, then RxValid=1 with RxData=0x5A.
REQ-037 PortSel=0, push 0x41, LSR=0x20 -> WE_L=0 at Address 0x0200 for exactly 4 cycles with BusWrData=0x41, then TxReady=1.
REQ-038 RX FIFO full (8 bytes) and LSR=0x21 with a TX byte pending -> WR_THR taken and RBR not read.
REQ-039 PortSel=3 with Enable=1 -> IOSelect_H stays 0 and Busy=0.
REQ-040 LSR=0x03 -> RxOverrun=1 and it stays 1 after 100 cycles; Reset_H pulse -> RxOverrun=0 and all REQ-032 values hold.
REQ-041 Reset_H at cycle 2 of WR_THR -> IOSelect_H=0 on the next edge and the TX FIFO is empty.

Source files
------------

// File: rtl/serial_io_pkg.sv
// Shared definitions for the UART poller: port map, register offsets, LSR bits
// and the polling FSM encoding.
package serial_io_pkg;

   localparam logic [15:0] BASE_BT   = 16'h0200;
   localparam logic [15:0] BASE_WIFI = 16'h0210;
   localparam logic [15:0] BASE_USB  = 16'h0220;

   localparam logic [3:0] OFS_RBR_THR = 4'h0;
   localparam logic [3:0] OFS_LSR     = 4'hA;

   localparam int unsigned LSR_DR   = 0;
   localparam int unsigned LSR_OE   = 1;
   localparam int unsigned LSR_THRE = 5;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RD_LSR = 3'd1,
      DECIDE = 3'd2,
      RD_RBR = 3'd3,
      WR_THR = 3'd4,
      GAP    = 3'd5
   } state_t;

   function automatic logic [15:0] port_base(input logic [1:0] sel);
      logic [15:0] base;
      unique case (sel)
         2'd0:    base = BASE_BT;
         2'd1:    base = BASE_WIFI;
         2'd2:    base = BASE_USB;
         default: base = 16'h0000;
      endcase
      return base;
   endfunction

endpackage

// File: rtl/sync_byte_fifo.sv
// Single-clock byte FIFO with a registered head output; a pop frees its slot
// for a same-cycle push, while a push into an empty FIFO is not bypassed.
module sync_byte_fifo #(
   parameter int unsigned DEPTH = 8
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_push,
   input  logic [7:0] i_data,
   input  logic       i_pop,
   output logic [7:0] o_data,
   output logic       o_full,
   output logic       o_empty
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = AW + 1;

   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wr;
   logic [AW-1:0] r_rd;
   logic [CW-1:0] r_count;
   logic [7:0]    r_head;

   logic          w_push;
   logic          w_pop;
   logic [AW-1:0] w_rd_next;
   logic [7:0]    w_head_next;

   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == CW'(DEPTH));
   assign w_pop     = i_pop && !o_empty;
   assign w_push    = i_push && (!o_full || w_pop);
   assign w_rd_next = w_pop ? r_rd + AW'(1) : r_rd;
   assign o_data    = r_head;

   // Head register follows the slot the read pointer will point at next cycle.
   always_comb begin
      w_head_next = r_mem[w_rd_next];
      if (w_push && (r_wr == w_rd_next)) begin
         w_head_next = i_data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wr] <= i_data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
         r_head  <= '0;
      end else begin
         if (w_push) begin
            r_wr <= r_wr + AW'(1);
         end
         r_rd    <= w_rd_next;
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
         r_head  <= w_head_next;
      end
   end

endmodule

// File: rtl/serial_io_poller.sv
// Polls one of three 16550-style UARTs over an 8-bit IO window, moving bytes
// between the UART and local RX/TX FIFOs.
module serial_io_poller
   import serial_io_pkg::*;
#(
   parameter int unsigned BUS_WAIT   = 4,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned POLL_GAP   = 2
) (
   input  logic        Clock,
   input  logic        Reset_H,
   input  logic        Enable,
   input  logic [1:0]  PortSel,
   input  logic [7:0]  TxData,
   input  logic        TxValid,
   output logic        TxReady,
   output logic [7:0]  RxData,
   output logic        RxValid,
   input  logic        RxReady,
   output logic [15:0] Address,
   output logic        IOSelect_H,
   output logic        ByteSelect_L,
   output logic        WE_L,
   output logic [7:0]  BusWrData,
   input  logic [7:0]  BusRdData,
   output logic        Busy,
   output logic        RxOverrun
);

   localparam int unsigned GAP_LEN   = (POLL_GAP < 1) ? 1 : POLL_GAP;
   localparam logic [7:0]  WAIT_LAST = 8'(BUS_WAIT - 1);
   localparam logic [7:0]  GAP_LAST  = 8'(GAP_LEN - 1);

   state_t     r_state;
   logic [7:0] r_cnt;
   logic [1:0] r_sel;
   logic [7:0] r_lsr;
   logic       r_overrun;

   state_t     w_state_d;
   logic [7:0] w_cnt_d;
   logic [1:0] w_sel_d;
   logic [7:0] w_lsr_d;
   logic       w_overrun_d;
   logic       w_last;
   logic       w_access;
   logic [3:0] w_ofs;
   logic       w_we_l;
   logic       w_rx_push;
   logic       w_tx_pop;
   logic       w_rx_full;
   logic       w_rx_empty;
   logic       w_tx_full;
   logic       w_tx_empty;
   logic [7:0] w_tx_head;

   always_ff @(posedge Clock) begin
      if (Reset_H) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_sel     <= '0;
         r_lsr     <= '0;
         r_overrun <= 1'b0;
      end else begin
         r_state   <= w_state_d;
         r_cnt     <= w_cnt_d;
         r_sel     <= w_sel_d;
         r_lsr     <= w_lsr_d;
         r_overrun <= w_overrun_d;
      end
   end

   // r_cnt counts down the remaining cycles of the current access or gap.
   always_comb begin
      w_state_d   = r_state;
      w_cnt_d     = r_cnt;
      w_sel_d     = r_sel;
      w_lsr_d     = r_lsr;
      w_overrun_d = r_overrun;
      w_access    = 1'b0;
      w_ofs       = OFS_RBR_THR;
      w_we_l      = 1'b1;
      w_rx_push   = 1'b0;
      w_tx_pop    = 1'b0;
      w_last      = (r_cnt == '0);
      unique case (r_state)
         IDLE: begin
            if (Enable && (PortSel != 2'd3)) begin
               w_state_d = RD_LSR;
               w_sel_d   = PortSel;
               w_cnt_d   = WAIT_LAST;
            end
         end
         RD_LSR: begin
            w_access = 1'b1;
            w_ofs    = OFS_LSR;
            if (w_last) begin
               w_lsr_d = BusRdData;
               if (BusRdData[LSR_OE]) begin
                  w_overrun_d = 1'b1;
               end
               if (Enable) begin
                  w_state_d = DECIDE;
               end else begin
                  w_state_d = GAP;
                  w_cnt_d   = '0;
               end
            end else begin
               w_cnt_d = r_cnt - 8'd1;
            end
         end
         DECIDE: begin
            if (!Enable) begin
               w_state_d = GAP;
               w_cnt_d   = '0;
            end else if (r_lsr[LSR_DR] && !w_rx_full) begin
               w_state_d = RD_RBR;
               w_cnt_d   = WAIT_LAST;
            end else if (r_lsr[LSR_THRE] && !w_tx_empty) begin
               w_state_d = WR_THR;
               w_cnt_d   = WAIT_LAST;
            end else begin
               w_state_d = GAP;
               w_cnt_d   = GAP_LAST;
            end
         end
         RD_RBR: begin
            w_access = 1'b1;
            if (w_last) begin
               w_rx_push = 1'b1;
               w_state_d = GAP;
               w_cnt_d   = '0;
            end else begin
               w_cnt_d = r_cnt - 8'd1;
            end
         end
         WR_THR: begin
            w_access = 1'b1;
            w_we_l   = 1'b0;
            if (w_last) begin
               w_tx_pop  = 1'b1;
               w_state_d = GAP;
               w_cnt_d   = '0;
            end else begin
               w_cnt_d = r_cnt - 8'd1;
            end
         end
         GAP: begin
            if (w_last) begin
               w_state_d = IDLE;
            end else begin
               w_cnt_d = r_cnt - 8'd1;
            end
         end
         default: begin
            w_state_d = IDLE;
         end
      endcase
   end

   assign IOSelect_H   = w_access;
   assign ByteSelect_L = !w_access;
   assign WE_L         = w_we_l;
   assign Address      = w_access ? (port_base(r_sel) | {12'h000, w_ofs}) : 16'h0000;
   assign BusWrData    = (r_state == WR_THR) ? w_tx_head : 8'h00;
   assign Busy         = (r_state != IDLE);
   assign RxOverrun    = r_overrun;
   assign TxReady      = !w_tx_full;
   assign RxValid      = !w_rx_empty;

   sync_byte_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_rx_fifo (
      .i_clk   (Clock),
      .i_rst   (Reset_H),
      .i_push  (w_rx_push),
      .i_data  (BusRdData),
      .i_pop   (RxReady),
      .o_data  (RxData),
      .o_full  (w_rx_full),
      .o_empty (w_rx_empty)
   );

   sync_byte_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_tx_fifo (
      .i_clk   (Clock),
      .i_rst   (Reset_H),
      .i_push  (TxValid),
      .i_data  (TxData),
      .i_pop   (w_tx_pop),
      .o_data  (w_tx_head),
      .o_full  (w_tx_full),
      .o_empty (w_tx_empty)
   );

endmodule
